// File: rtl/ro_puf_controller.sv
// Sequencer for the ring-oscillator PUF: walks RESP_BITS oscillator pairs per
// challenge, gating each pair for a programmed window and comparing edge counts.
module ro_puf_controller #(
    parameter int NUM_RO     = 16,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic [WIN_W-1:0]     window_len,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 resp_valid,
    output logic                 err,
    output logic [SEL_W-1:0]     tie_cnt
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIN_W-1:0]     cnt_q, cnt_d;
    logic [WIN_W-1:0]     win_len_q, win_len_d;
    logic [SEL_W-1:0]     base_a_q, base_a_d;
    logic [SEL_W-1:0]     base_b_q, base_b_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d;
    logic [SEL_W-1:0]     sel_b_q, sel_b_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 err_q, err_d;
    logic [SEL_W-1:0]     tie_q, tie_d;

    function automatic logic [SEL_W-1:0] pair_a(input logic [SEL_W-1:0] base,
                                                input logic [IDX_W-1:0] i);
        return base + SEL_W'(i);
    endfunction

    // A pair must never compare an oscillator against itself; bump B past A.
    function automatic logic [SEL_W-1:0] pair_b(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] base,
                                                input logic [IDX_W-1:0] i);
        logic [SEL_W-1:0] b;
        b = base + SEL_W'(i);
        return (b == a) ? a + SEL_W'(1) : b;
    endfunction

    // NOTE: every next-state signal defaults to its current value before the
    // case statement, so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        win_len_d    = win_len_q;
        base_a_d     = base_a_q;
        base_b_d     = base_b_q;
        sel_a_d      = sel_a_q;
        sel_b_d      = sel_b_q;
        response_d   = response_q;
        resp_valid_d = resp_valid_q;
        err_d        = err_q;
        tie_d        = tie_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (window_len == '0) begin
                        err_d        = 1'b1;
                        resp_valid_d = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        base_a_d     = challenge[SEL_W-1:0];
                        base_b_d     = challenge[2*SEL_W-1:SEL_W];
                        win_len_d    = window_len;
                        response_d   = '0;
                        resp_valid_d = 1'b0;
                        err_d        = 1'b0;
                        tie_d        = '0;
                        idx_d        = '0;
                        sel_a_d      = pair_a(challenge[SEL_W-1:0], '0);
                        sel_b_d      = pair_b(sel_a_d, challenge[2*SEL_W-1:SEL_W], '0);
                        state_d      = S_CLEAR;
                    end
                end
            end

            S_CLEAR: begin
                cnt_d   = win_len_q - WIN_W'(1);
                state_d = S_RUN;
            end

            S_RUN: begin
                if (cnt_q == '0) begin
                    cnt_d   = WIN_W'(SETTLE_CYC - 1);
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - WIN_W'(1);
                end
            end

            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_COMPARE;
                else             cnt_d   = cnt_q - WIN_W'(1);
            end

            S_COMPARE: begin
                response_d[idx_q] = (cnt_a > cnt_b);
                if (cnt_a == cnt_b && tie_q != '1) tie_d = tie_q + SEL_W'(1);
                if (cnt_a == '1 || cnt_b == '1)    err_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    sel_a_d = pair_a(base_a_q, idx_d);
                    sel_b_d = pair_b(sel_a_d, base_b_q, idx_d);
                    state_d = S_CLEAR;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all state,
    // including the response register, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            win_len_q    <= '0;
            base_a_q     <= '0;
            base_b_q     <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            response_q   <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            tie_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            win_len_q    <= win_len_d;
            base_a_q     <= base_a_d;
            base_b_q     <= base_b_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            response_q   <= response_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            tie_q        <= tie_d;
        end
    end

    // Strobes decode the registered state, so reset removes ro_en without a clock.
    assign ro_en      = (state_q == S_RUN);
    assign cnt_clr    = (state_q == S_CLEAR);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign sel_a      = sel_a_q;
    assign sel_b      = sel_b_q;
    assign response   = response_q;
    assign resp_valid = resp_valid_q;
    assign err        = err_q;
    assign tie_cnt    = tie_q;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Directed bench for ro_puf_controller: a behavioural counter datapath feeds
// per-pair counts; expected results are queued at start and compared at done.
module tb_ro_puf_controller;

    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  challenge = '0;
    logic [15:0] window_len = '0;
    logic [15:0] cnt_a = '0;
    logic [15:0] cnt_b = '0;
    logic        ro_en, cnt_clr, busy, done, resp_valid, err;
    logic [3:0]  sel_a, sel_b, tie_cnt;
    logic [7:0]  response;

    ro_puf_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .challenge  (challenge),
        .window_len (window_len),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .ro_en      (ro_en),
        .cnt_clr    (cnt_clr),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .resp_valid (resp_valid),
        .err        (err),
        .tie_cnt    (tie_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] resp;
        logic       valid;
        logic       err;
        logic [3:0] tie;
        logic       chk_tie;
        int         lat;
        int         ro;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] ca[8];
    logic [15:0] cb[8];
    logic [3:0]  seq_a[8];
    logic [3:0]  seq_b[8];
    int          done_at, ro_cnt, nclr, unstable, busy_gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] resp, input logic valid, input logic e,
                            input logic [3:0] tie, input logic chk_tie,
                            input int lat, input int ro);
        exp_t x;
        x.resp = resp; x.valid = valid; x.err = e; x.tie = tie;
        x.chk_tie = chk_tie; x.lat = lat; x.ro = ro;
        sb.push_back(x);
    endtask

    // Runs one evaluation, acting as the counter datapath; optionally pulses
    // start again at step extra_k while the controller is busy.
    task automatic run_eval(input logic [7:0] ch, input logic [15:0] wl, input int extra_k);
        logic [3:0] a_base;
        a_base = ch[3:0];
        @(negedge clk);
        challenge = ch; window_len = wl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        challenge = ~ch; window_len = wl + 16'd3;
        done_at = -1; ro_cnt = 0; nclr = 0; unstable = 0; busy_gap = 0;
        for (int k = 0; k < LIMIT; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            start = (k == extra_k);
            cnt_a = ca[3'(sel_a - a_base)];
            cnt_b = cb[3'(sel_a - a_base)];
            if (ro_en) ro_cnt++;
            if (!busy) busy_gap++;
            if (cnt_clr) begin
                if (nclr < 8) begin seq_a[nclr] = sel_a; seq_b[nclr] = sel_b; end
                nclr++;
            end else if (busy && !done && nclr > 0 && nclr <= 8 &&
                         (sel_a !== seq_a[nclr-1] || sel_b !== seq_b[nclr-1])) begin
                unstable++;
            end
            if (done) begin done_at = k; break; end
        end
        start = 1'b0;
    endtask

    task automatic check_eval(input string name);
        exp_t e;
        e = sb.pop_front();
        chk({name, "_latency"},  done_at,    e.lat);
        chk({name, "_response"}, response,   e.resp);
        chk({name, "_valid"},    resp_valid, e.valid);
        chk({name, "_err"},      err,        e.err);
        if (e.chk_tie) chk({name, "_tie"}, tie_cnt, e.tie);
        chk({name, "_ro_cycles"}, ro_cnt,    e.ro);
        chk({name, "_busy_gap"}, busy_gap,   0);
        chk({name, "_sel_stable"}, unstable, 0);
        @(posedge clk); #1;
        chk({name, "_post_done"}, {done, busy}, 2'b00);
    endtask

    task automatic chk_seq(input string name, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ea, eb;
        chk({name, "_pairs"}, nclr, 8);
        for (int i = 0; i < 8; i++) begin
            ea = a + 4'(i);
            eb = b + 4'(i);
            if (eb == ea) eb = ea + 4'd1;
            chk($sformatf("%s_sel%0d", name, i), {seq_a[i], seq_b[i]}, {ea, eb});
        end
    endtask

    task automatic set_table_alt();
        for (int i = 0; i < 8; i++) begin
            ca[i] = (i % 2 == 0) ? 16'd105 : 16'd100;
            cb[i] = (i % 2 == 0) ? 16'd100 : 16'd105;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {ro_en, cnt_clr, sel_a, sel_b, busy, done, response, resp_valid, err, tie_cnt}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy, done}, 2'b00);

        // Alternating winners: A wins even pairs, B wins odd pairs.
        set_table_alt();
        push_exp(8'h55, 1'b1, 1'b0, 4'd0, 1'b1, 64, 32);
        run_eval(8'h10, 16'd4, -1);
        check_eval("alt");
        chk_seq("alt", 4'd0, 4'd1);

        // Zero window is rejected; previous response is kept.
        push_exp(8'h55, 1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        run_eval(8'h00, 16'd0, -1);
        check_eval("zero_win");

        // Colliding bases, all counts tied.
        for (int i = 0; i < 8; i++) begin ca[i] = 16'd700; cb[i] = 16'd700; end
        push_exp(8'h00, 1'b1, 1'b0, 4'd8, 1'b1, 64, 32);
        run_eval(8'h33, 16'd4, -1);
        check_eval("ties");
        chk_seq("ties", 4'd3, 4'd3);

        // B base 15 wraps to 0; one tie at pair 5, A wins pairs 6 and 7.
        for (int i = 0; i < 8; i++) begin ca[i] = 16'(i * 10); cb[i] = 16'd50; end
        push_exp(8'hC0, 1'b1, 1'b0, 4'd1, 1'b1, 48, 16);
        run_eval(8'hF0, 16'd2, -1);
        check_eval("wrap");
        chk_seq("wrap", 4'd0, 4'd15);

        // Saturated count on pair 3, plus an ignored second start while busy.
        for (int i = 0; i < 8; i++) begin ca[i] = 16'd10; cb[i] = 16'd20; end
        ca[3] = 16'hFFFF;
        push_exp(8'h08, 1'b1, 1'b1, 4'd0, 1'b1, 56, 24);
        run_eval(8'h10, 16'd3, 10);
        check_eval("saturate");

        // Asynchronous reset in the RUN window of pair 2.
        cnt_a = 16'd200; cnt_b = 16'd100;
        @(negedge clk);
        challenge = 8'h10; window_len = 16'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (55) @(posedge clk);
        #1;
        chk("midrun_pre", {ro_en, busy, response}, {1'b1, 1'b1, 8'h03});
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset", {ro_en, busy, response, resp_valid, err}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrun_idle", {busy, done, ro_en}, 3'b000);

        set_table_alt();
        push_exp(8'h55, 1'b1, 1'b0, 4'd0, 1'b1, 40, 8);
        run_eval(8'h10, 16'd1, -1);
        check_eval("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
